// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared types and default limits for the RC receiver front ends
package quad_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2
  } rx_state_e;

  localparam int PW_W           = 12;
  localparam int PW_MIN_US      = 800;
  localparam int PW_MAX_US      = 2200;
  localparam int RX_TIMEOUT_US  = 50000;
  localparam int FILT_LEN_DEF   = 8;
  localparam int ONLINE_CNT_DEF = 3;

endpackage

// File: rtl/rx_deglitch.sv
// rtl/rx_deglitch.sv - two-flop synchroniser plus hold-time filter with edge strobes
module rx_deglitch #(
  parameter int FILT_LEN = 8
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_rx,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_toggle;

  assign w_diff   = r_sync2 ^ r_level;
  assign w_toggle = w_diff && (r_cnt == CNT_LAST);

  // Level resets high so a pulse already in progress at startup is never measured.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_rise  <= w_toggle & ~r_level;
      r_fall  <= w_toggle & r_level;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_toggle) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/rc_pwm_capture.sv
// rtl/rc_pwm_capture.sv - RC servo pulse width capture with range check and link health
module rc_pwm_capture
  import quad_pkg::*;
#(
  parameter int FILT_LEN   = FILT_LEN_DEF,
  parameter int PW_MIN     = PW_MIN_US,
  parameter int PW_MAX     = PW_MAX_US,
  parameter int TIMEOUT_US = RX_TIMEOUT_US,
  parameter int ONLINE_CNT = ONLINE_CNT_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_stb_1m,
  input  logic            i_rx,
  output logic [PW_W-1:0] o_pw,
  output logic            o_new_pw,
  output logic            o_online,
  output logic            o_err
);

  localparam int GW = $clog2(ONLINE_CNT + 1);
  localparam logic [PW_W-1:0] PW_MIN_C  = PW_W'(PW_MIN);
  localparam logic [PW_W-1:0] PW_MAX_C  = PW_W'(PW_MAX);
  localparam logic [15:0]     TIMEOUT_C = 16'(TIMEOUT_US);
  localparam logic [GW-1:0]   GOOD_MAX  = GW'(ONLINE_CNT);

  logic            w_level;
  logic            w_rise;
  logic            w_fall;
  rx_state_e       r_state;
  rx_state_e       w_state_nxt;
  logic [PW_W-1:0] r_cnt;
  logic [PW_W-1:0] w_cnt_nxt;
  logic            w_commit;
  logic            w_reject;
  logic [PW_W-1:0] r_pw;
  logic            r_new_pw;
  logic            r_online;
  logic            r_err;
  logic [15:0]     r_timer;
  logic [GW-1:0]   r_good;
  logic [GW-1:0]   w_good_inc;

  rx_deglitch #(.FILT_LEN(FILT_LEN)) u_deglitch (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_rx      (i_rx),
    .o_level   (w_level),
    .o_rise    (w_rise),
    .o_fall    (w_fall)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= WAIT_LOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A strobe coinciding with the fall is dropped: the width is judged as counted so far.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      WAIT_LOW: begin
        if (!w_level) w_state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (w_rise) begin
          w_state_nxt = MEASURE;
          w_cnt_nxt   = '0;
        end
      end
      MEASURE: begin
        if (w_fall) begin
          w_state_nxt = WAIT_RISE;
          if (r_cnt >= PW_MIN_C && r_cnt <= PW_MAX_C) w_commit = 1'b1;
          else                                        w_reject = 1'b1;
        end else if (r_cnt > PW_MAX_C) begin
          w_reject    = 1'b1;
          w_state_nxt = WAIT_LOW;
        end else if (i_stb_1m && r_cnt != '1) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = WAIT_LOW;
    endcase
  end

  assign w_good_inc = (r_good == GOOD_MAX) ? r_good : r_good + 1'b1;

  // A commit takes priority over a timeout expiring in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pw     <= '0;
      r_new_pw <= 1'b0;
      r_online <= 1'b0;
      r_err    <= 1'b0;
      r_timer  <= '0;
      r_good   <= '0;
    end else begin
      r_new_pw <= w_commit;
      r_err    <= w_reject;
      if (w_commit) begin
        r_pw    <= r_cnt;
        r_timer <= '0;
        r_good  <= w_good_inc;
        if (w_good_inc == GOOD_MAX) r_online <= 1'b1;
      end else begin
        if (i_stb_1m && r_timer != '1) r_timer <= r_timer + 1'b1;
        if (w_reject) r_good <= '0;
        if (r_timer >= TIMEOUT_C) begin
          r_online <= 1'b0;
          r_good   <= '0;
        end
      end
    end
  end

  assign o_pw     = r_pw;
  assign o_new_pw = r_new_pw;
  assign o_online = r_online;
  assign o_err    = r_err;

endmodule

// File: tb/tb_rc_pwm_capture.sv
// tb/tb_rc_pwm_capture.sv - directed self-checking bench for rc_pwm_capture (scaled limits, 1 us = 2 clocks)
module tb_rc_pwm_capture;

  localparam int GAP = 300;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb   = 1'b0;
  logic        rx    = 1'b0;
  logic [11:0] pw;
  logic        new_pw;
  logic        online;
  logic        err;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_new = 0;
  int n_err = 0;
  int n_rise = 0;
  int last_pw = 0;
  int t_commit = 0;
  int t_err = 0;
  int c0 = 0;
  int new0 = 0;
  int err0 = 0;
  int rise0 = 0;

  rc_pwm_capture #(
    .FILT_LEN   (8),
    .PW_MIN     (200),
    .PW_MAX     (550),
    .TIMEOUT_US (2000),
    .ONLINE_CNT (3)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_stb_1m  (stb),
    .i_rx      (rx),
    .o_pw      (pw),
    .o_new_pw  (new_pw),
    .o_online  (online),
    .o_err     (err)
  );

  always #10 clk = ~clk;
  always @(negedge clk) stb = ~stb;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (new_pw) begin
      n_new++;
      last_pw  = int'(pw);
      t_commit = cyc;
    end
    if (err) begin
      n_err++;
      t_err = cyc;
    end
    if (dut.w_rise) n_rise++;
  end

  initial begin
    #(20 * 150000);
    $display("FAIL watchdog: run exceeded 150000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // High for 2*w+1 clocks so exactly w strobes land inside the measured window.
  task automatic pulse(input int w_us);
    rx = 1'b1;
    clocks(2 * w_us + 1);
    rx = 1'b0;
    clocks(2 * GAP);
  endtask

  initial begin
    clocks(5);
    chk("reset_pw", pw, 0);
    chk("reset_new_pw", new_pw, 0);
    chk("reset_online", online, 0);
    chk("reset_err", err, 0);
    rst_n = 1'b1;
    clocks(200);

    pulse(375);
    chk("p1_new", n_new, 1);
    chk("p1_pw", pw, 375);
    chk("p1_online", online, 0);
    pulse(375);
    chk("p2_new", n_new, 2);
    chk("p2_pw", last_pw, 375);
    chk("p2_online", online, 0);
    pulse(375);
    chk("p3_new", n_new, 3);
    chk("p3_pw", pw, 375);
    chk("p3_online", online, 1);
    chk("p3_no_err", n_err, 0);

    pulse(125);
    chk("short_err", n_err, 1);
    chk("short_pw_hold", pw, 375);
    chk("short_no_new", n_new, 3);
    pulse(300);
    chk("p300_pw", pw, 300);
    chk("p300_new", n_new, 4);
    chk("p300_online", online, 1);
    pulse(199);
    chk("min_minus1_err", n_err, 2);
    chk("min_minus1_pw", pw, 300);
    pulse(200);
    chk("min_pw", pw, 200);
    chk("min_new", n_new, 5);
    pulse(551);
    chk("max_plus1_err", n_err, 3);
    chk("max_plus1_pw", pw, 200);
    pulse(550);
    chk("max_pw", pw, 550);
    chk("max_new", n_new, 6);
    chk("max_online", online, 1);

    c0 = cyc;
    pulse(750);
    chk("stuck_err", n_err, 4);
    chk("stuck_no_new", n_new, 6);
    chk("stuck_err_time", (t_err - c0 >= 1105 && t_err - c0 <= 1120), 1);
    pulse(250);
    chk("after_stuck_pw", pw, 250);
    chk("after_stuck_online", online, 1);

    while (cyc < t_commit + 3990) @(negedge clk);
    chk("before_timeout_online", online, 1);
    while (cyc < t_commit + 4010) @(negedge clk);
    chk("timeout_online", online, 0);
    chk("timeout_pw_hold", pw, 250);
    pulse(375);
    pulse(375);
    chk("relink_p2_online", online, 0);
    pulse(375);
    chk("relink_p3_online", online, 1);
    chk("relink_new", n_new, 10);

    err0  = n_err;
    rise0 = n_rise;
    rx = 1'b1;
    clocks(400);
    rx = 1'b0;
    clocks(3);
    rx = 1'b1;
    clocks(2 * 450 + 1 - 403);
    rx = 1'b0;
    clocks(GAP);
    rx = 1'b1;
    clocks(3);
    rx = 1'b0;
    clocks(GAP);
    chk("glitch_pw", pw, 450);
    chk("glitch_rises", n_rise - rise0, 1);
    chk("glitch_no_err", n_err, err0);

    new0 = n_new;
    err0 = n_err;
    rx = 1'b1;
    clocks(200);
    rst_n = 1'b0;
    clocks(5);
    rst_n = 1'b1;
    clocks(1);
    chk("midreset_pw", pw, 0);
    chk("midreset_online", online, 0);
    chk("midreset_new_pw", new_pw, 0);
    chk("midreset_err", err, 0);
    clocks(200);
    rx = 1'b0;
    clocks(2 * GAP);
    chk("midreset_tail_no_new", n_new, new0);
    chk("midreset_tail_no_err", n_err, err0);
    pulse(400);
    chk("post_reset_pw", pw, 400);
    chk("post_reset_new", n_new, new0 + 1);
    chk("post_reset_online", online, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
